seq_pattern_tx: RTL
===================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum payload length in bits (2..32).
REQ-002 SHALL have parameter IDLE_LVL, default 1'b0, meaning the level driven on X when no bit is being sent.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  a pattern is offered.
REQ-006 SHALL have port in_ready  output  1  the block accepts a pattern this cycle.
REQ-007 SHALL have port in_data  input  MAX_LEN  pattern bits, sent MSB-first starting at bit in_len-1.
REQ-008 SHALL have port in_len  input  LW=$clog2(MAX_LEN+1)  number of payload bits.
REQ-009 SHALL have port in_repeat  input  4  number of extra back-to-back repetitions (0 = send once).
REQ-010 SHALL have port X  output  1  serial bit stream, matching the detector-side X input.
REQ-011 SHALL have port x_valid  output  1  X carries a pattern bit this cycle.
REQ-012 SHALL have port busy  output  1  a frame is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement states IDLE, SHIFT, PAR, DONE.
- IDLE->SHIFT on in_valid&&in_ready with in_len>0.
- IDLE->DONE on handshake with in_len==0.
- SHIFT->PAR after the last payload bit when parity is enabled; otherwise SHIFT->SHIFT (repeats left) or SHIFT->DONE.
- PAR->SHIFT (repeats left) or PAR->DONE.
- DONE->IDLE unconditionally.
REQ-015 SHALL drive in_ready high only in IDLE, so at most one frame is accepted at a time.
REQ-016 SHALL capture in_data, in_len and in_repeat on handshake and ignore all in_* inputs until the next IDLE.
REQ-017 SHALL present the first bit on X with x_valid=1 in the cycle after the handshake (1-cycle latency), then one bit per cycle.
REQ-018 SHALL send in_len*(in_repeat+1) payload bits with no gaps between repetitions; each repetition restarts at bit in_len-1.
REQ-019 SHALL clamp in_len values greater than MAX_LEN to MAX_LEN.
REQ-020 SHALL drive X=IDLE_LVL and x_valid=0 in IDLE and DONE.
REQ-021 SHALL assert done for exactly the DONE cycle; busy SHALL be high in SHIFT, PAR and DONE.
REQ-022 SHALL allow in_valid held high continuously to give back-to-back frames separated by exactly one idle cycle (DONE), then one handshake cycle.
REQ-023 SHALL never assert x_valid during a frame with in_len==0.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-frame, immediately force state=IDLE, X=IDLE_LVL, x_valid=0, busy=0, done=0 and in_ready=0, and discard any captured pattern.
REQ-025 SHALL assert in_ready in the first clock edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when SEQ_TX_PARITY_EN is defined, append one even-parity bit (XOR of that repetition's payload bits) with x_valid=1 after each repetition, via state PAR.
REQ-027 SHALL, when SEQ_TX_PARITY_EN is undefined, contain no PAR state or parity logic, and frames SHALL be payload-only.

Structure
REQ-028 SHALL import shared package seq_pkg containing the state enum type seq_tx_state_t, the default MAX_LEN constant and the LW width function.
REQ-029 SHALL instantiate one sub-module, seq_tx_shreg: a loadable MSB-first shift register with bit counter, reload-for-repeat input and last-bit flag.

Verification
REQ-030 SHALL verify: in_data=4'b0100, in_len=4, in_repeat=0 -> X=0,1,0,0 with x_valid on cycles 1-4 after handshake, done on cycle 5.
REQ-031 SHALL verify: in_data=3'b100, in_len=3, in_repeat=2 -> X=1,0,0,1,0,0,1,0,0 over 9 consecutive cycles, a single done pulse, then in_ready high.
REQ-032 SHALL verify: in_len=0 -> done one cycle after handshake, x_valid never asserted.
REQ-033 SHALL verify: rst_n pulled low during bit 2 of a 4-bit frame -> X=IDLE_LVL and x_valid=0 immediately with no clock edge, no done pulse, and in_ready high after release.
REQ-034 SHALL verify, with SEQ_TX_PARITY_EN defined: in_data=3'b010, in_len=3 -> X=0,1,0,1, then done.
REQ-035 SHALL verify: in_valid held high with in_len=20 at MAX_LEN=16 -> 16 bits per frame, frames separated by one idle cycle plus one handshake cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for the serial pattern transmitter.
//   SEQ_MAX_LEN    : default payload length limit in bits
//   seq_lw()       : width of a length field able to hold 0..max_len
//   seq_tx_state_t : transmitter FSM states (PAR exists only when
//                    SEQ_TX_PARITY_EN is defined)
package seq_pkg;

  localparam int SEQ_MAX_LEN = 16;

  function automatic int seq_lw(input int max_len);
    return $clog2(max_len + 1);
  endfunction

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} seq_tx_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} seq_tx_state_t;
`endif

endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg -- loadable MSB-first shift register with bit counter.
//   load      : capture load_data/load_len; bit load_len-1 lands on bit_out
//   reload    : restart the captured pattern (next repetition)
//   shift     : advance one bit
//   load_data : pattern bits, load_len : payload length (already clamped)
//   bit_out   : current bit, last : current bit is the final one of the pattern
module seq_tx_shreg import seq_pkg::*; #(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int LW      = seq_lw(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               reload,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic [LW-1:0]      load_len,
  output logic               bit_out,
  output logic               last
);

  logic [MAX_LEN-1:0] img_q, sh_q, aligned;
  logic [LW-1:0]      len_q, cnt_q;

  // Left-justify so bit load_len-1 sits at the MSB; bits above load_len
  // fall off the top and the vacated low bits are zero.
  assign aligned = load_data << (LW'(MAX_LEN) - load_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= '0;
      sh_q  <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      img_q <= aligned;
      sh_q  <= aligned;
      len_q <= load_len;
      cnt_q <= load_len;
    end else if (reload) begin
      sh_q  <= img_q;
      cnt_q <= len_q;
    end else if (shift) begin
      sh_q  <= {sh_q[MAX_LEN-2:0], 1'b0};
      cnt_q <= cnt_q - LW'(1);
    end
  end

  assign bit_out = sh_q[MAX_LEN-1];
  assign last    = (cnt_q == LW'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx -- serialises a captured pattern MSB-first on X, optionally
// repeated back-to-back, with an optional even-parity bit after each
// repetition (macro SEQ_TX_PARITY_EN).
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : pattern handshake (ready only in IDLE)
//   in_data/in_len      : pattern bits and length (clamped to MAX_LEN)
//   in_repeat           : extra repetitions (0 = send once)
//   X/x_valid           : serial bit and its qualifier
//   busy/done           : frame in progress / one-cycle completion pulse
module seq_pattern_tx import seq_pkg::*; #(
  parameter int   MAX_LEN  = SEQ_MAX_LEN,
  parameter logic IDLE_LVL = 1'b0,
  localparam int  LW       = seq_lw(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_data,
  input  logic [LW-1:0]      in_len,
  input  logic [3:0]         in_repeat,
  output logic               X,
  output logic               x_valid,
  output logic               busy,
  output logic               done
);

  seq_tx_state_t state_q, state_d;
  logic          rdy_q;
  logic [3:0]    rep_q;
  logic [LW-1:0] len_c;
  logic          hs, load, reload, shift, rep_dec;
  logic          sh_bit, sh_last;

  assign len_c = (in_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : in_len;
  assign hs    = in_valid && in_ready;

  // Held low through reset so in_ready stays low until the first edge
  // after release, even though the state is already IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load)         rep_q <= in_repeat;
      else if (rep_dec) rep_q <= rep_q - 4'd1;
    end
  end

`ifdef SEQ_TX_PARITY_EN
  logic               par_q;
  logic [MAX_LEN-1:0] len_mask;

  // Parity is identical for every repetition, so compute it once at capture.
  assign len_mask = ~({MAX_LEN{1'b1}} << len_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    par_q <= 1'b0;
    else if (load) par_q <= ^(in_data & len_mask);
  end
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    reload  = 1'b0;
    shift   = 1'b0;
    rep_dec = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        load    = 1'b1;
        state_d = (len_c == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (!sh_last) begin
          shift = 1'b1;
        end else begin
`ifdef SEQ_TX_PARITY_EN
          state_d = PAR;
`else
          if (rep_q != 4'd0) begin
            reload  = 1'b1;
            rep_dec = 1'b1;
          end else begin
            state_d = DONE;
          end
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PAR: begin
        if (rep_q != 4'd0) begin
          reload  = 1'b1;
          rep_dec = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  seq_tx_shreg #(.MAX_LEN(MAX_LEN), .LW(LW)) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .reload    (reload),
    .shift     (shift),
    .load_data (in_data),
    .load_len  (len_c),
    .bit_out   (sh_bit),
    .last      (sh_last)
  );

  // Outputs decode the registered state only, so an async reset reaches
  // them without waiting for a clock edge.
  always_comb begin
    X       = IDLE_LVL;
    x_valid = 1'b0;
    case (state_q)
      SHIFT: begin X = sh_bit; x_valid = 1'b1; end
`ifdef SEQ_TX_PARITY_EN
      PAR:   begin X = par_q;  x_valid = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign in_ready = (state_q == IDLE) && rdy_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
